// File: rtl/seg_scan_ctrl_if.sv
// seg_scan_ctrl_if -- code-load handshake and display bus of the segment scanner.
//   code_in    : packed segment codes, 8 bits per digit, digit 0 in [7:0]
//   load_req   : level request to capture code_in (hold code_in stable while high)
//   load_ack   : one-cycle pulse when code_in lands in the shadow register
//   seg        : shared segment bus, active-high (bit7=a .. bit1=g, bit0=dp)
//   dig_sel    : digit enables, active-low
//   frame_done : one-cycle pulse on the last cycle of each scan frame
// modport slave  : the scan controller
// modport master : the code producer / display side
interface seg_scan_ctrl_if #(
  parameter int NUM_DIGITS = 3
);
  logic [8*NUM_DIGITS-1:0] code_in;
  logic                    load_req;
  logic                    load_ack;
  logic [7:0]              seg;
  logic [NUM_DIGITS-1:0]   dig_sel;
  logic                    frame_done;

  modport slave (
    input  code_in, load_req,
    output load_ack, seg, dig_sel, frame_done
  );

  modport master (
    output code_in, load_req,
    input  load_ack, seg, dig_sel, frame_done
  );
endinterface

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl -- time-multiplexed seven-segment scan controller.
// Each digit slot is CLK_DIV cycles: BLANK_CYC cycles with all digits off,
// then the digit is shown. The displayed code lives in a shadow register that
// is reloaded only at a frame boundary, when load_req is high.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous, active-low reset
//   bus : seg_scan_ctrl_if.slave (code_in/load_req in; load_ack/seg/dig_sel/frame_done out)
// Optional: define SEG_SCAN_LZ_SUPPRESS_EN to blank leading "0" digits
// (mask computed from code_in at capture time; digit 0 is never suppressed).
// All outputs are flops computed from internal state, so every output lags
// the internal counter/index/shadow by exactly one edge, consistently.
module seg_scan_ctrl #(
  parameter int NUM_DIGITS = 3,
  parameter int CLK_DIV    = 50000,
  parameter int BLANK_CYC  = 100
) (
  input  logic          clk,
  input  logic          rst,
  seg_scan_ctrl_if.slave bus
);
  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [0:0] ST_BLANK = 1'b0;
  localparam logic [0:0] ST_SHOW  = 1'b1;

  logic [CW-1:0]             cnt_q, cnt_d;
  logic [IW-1:0]             idx_q, idx_d;
  logic [0:0]                state_q, state_d;
  logic [8*NUM_DIGITS-1:0]   shadow_q, shadow_d;
  logic [7:0]                seg_q, seg_d;
  logic [NUM_DIGITS-1:0]     dig_sel_q, dig_sel_d;
  logic                      ack_q, ack_d;
  logic                      frame_q, frame_d;
  logic [NUM_DIGITS-1:0]     supp;

  logic slot_end;
  logic boundary;

  assign slot_end = (cnt_q == CW'(CLK_DIV - 1));
  assign boundary = slot_end && (idx_q == IW'(NUM_DIGITS - 1));

`ifdef SEG_SCAN_LZ_SUPPRESS_EN
  logic [NUM_DIGITS-1:0] mask_q, mask_d;
  logic [NUM_DIGITS-1:0] mask_new;

  // Walk from the most significant digit down: a "0" digit is suppressed
  // only while everything above it is "0" or blank.
  always_comb begin
    logic above_ok;
    mask_new = '0;
    above_ok = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      mask_new[k] = above_ok && (bus.code_in[8*k +: 8] == 8'hFC);
      above_ok    = above_ok && ((bus.code_in[8*k +: 8] == 8'hFC) ||
                                 (bus.code_in[8*k +: 8] == 8'h00));
    end
  end

  always_comb begin
    mask_d = mask_q;
    if (boundary && bus.load_req) mask_d = mask_new;
  end

  assign supp = mask_q;

  always_ff @(posedge clk) begin
    if (!rst) mask_q <= '0;
    else      mask_q <= mask_d;
  end
`else
  assign supp = '0;
`endif

  // Slot counter, digit index and phase.
  always_comb begin
    cnt_d   = slot_end ? '0 : cnt_q + 1'b1;
    idx_d   = idx_q;
    if (slot_end) idx_d = (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
    state_d = state_q;
    if (cnt_d == '0)               state_d = ST_BLANK;
    else if (cnt_d == CW'(BLANK_CYC)) state_d = ST_SHOW;
  end

  // Frame boundary handshake: capture and ack in the same cycle.
  always_comb begin
    frame_d  = boundary;
    ack_d    = boundary && bus.load_req;
    shadow_d = ack_d ? bus.code_in : shadow_q;
  end

  // Output decode from the current (pre-edge) state.
  always_comb begin
    seg_d     = 8'h00;
    dig_sel_d = '1;
    if (state_q == ST_SHOW) begin
      for (int k = 0; k < NUM_DIGITS; k++) begin
        if (idx_q == IW'(k) && !supp[k]) begin
          dig_sel_d[k] = 1'b0;
          seg_d        = shadow_q[8*k +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q     <= '0;
      idx_q     <= '0;
      state_q   <= ST_BLANK;
      shadow_q  <= '0;
      seg_q     <= 8'h00;
      dig_sel_q <= '1;
      ack_q     <= 1'b0;
      frame_q   <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      state_q   <= state_d;
      shadow_q  <= shadow_d;
      seg_q     <= seg_d;
      dig_sel_q <= dig_sel_d;
      ack_q     <= ack_d;
      frame_q   <= frame_d;
    end
  end

  assign bus.seg        = seg_q;
  assign bus.dig_sel    = dig_sel_q;
  assign bus.load_ack   = ack_q;
  assign bus.frame_done = frame_q;
endmodule
